noc_packet_tx: RTL
==================

# noc_packet_tx

Packet transmitter for the NoC TIE queue fabric. Acts as the initiator on both sides of the existing queue handshake: it pops a descriptor and payload words from a source queue's read side and pushes a framed packet (header, payload, checksum tail) into a destination queue's write side. It sits between a processor's outbound TIE queue and the router-facing queue, one instance per NoC output port.

## Interface
- SRC_ID, 8'h00: node ID placed in every header flit.
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  asynchronous, active-high reset.
- TIE_NoC_IN  in  32  head word of source queue; valid whenever TIE_NoC_IN_Empty=0.
- TIE_NoC_IN_Empty  in  1  source queue empty.
- TIE_NoC_IN_PopReq  out  1  pop request to source queue.
- TIE_NoC_OUT  out  32  flit to destination queue.
- TIE_NoC_OUT_Full  in  1  destination queue full.
- TIE_NoC_OUT_PushReq  out  1  push request to destination queue.
- busy  out  1  high in any state other than IDLE.
- pkt_count  out  16  packets completed (tail pushed), wraps at 16'hFFFF→0.

## Operation
- Handshake rules, both sides:
  - A pop is accepted at a posedge when PopReq=1 and Empty=0.
  - A push is accepted at a posedge when PushReq=1 and Full=0.
  - PopReq is asserted only when Empty=0. PushReq is asserted only when Full=0.
- Descriptor word: [31:24] dest, [23:8] ignored, [7:0] len (payload words, 0..255).
- Header flit: {dest, SRC_ID, seq[7:0], len}.
- Tail flit: XOR of all payload words; 32'h0 when len=0.
- FSM states IDLE, HDR, PAYLOAD, TAIL:
  - IDLE: PopReq = !Empty. On accept, latch dest and len, clear the checksum, go to HDR.
  - HDR: TIE_NoC_OUT = header, PushReq = !Full. On accept, go to PAYLOAD if len≠0, else TAIL. Load the remaining-word counter with len.
  - PAYLOAD: pass-through.
    - PopReq = PushReq = !Empty && !Full; TIE_NoC_OUT = TIE_NoC_IN.
    - On a transfer: checksum ^= word, counter decrements.
    - Go to TAIL when the transfer has counter=1.
  - TAIL: TIE_NoC_OUT = checksum, PushReq = !Full. On accept: seq+1 (8-bit wrap), pkt_count+1, go to IDLE.
- TIE_NoC_OUT = 32'h0 in IDLE.
- Reset (any time):
  - Return to IDLE; seq, pkt_count, counter, checksum and latched fields cleared.
  - A packet in flight is truncated: no tail is pushed. Its unpopped source words stay in the source queue.
  - No push or pop may be issued in the reset cycle.
- Reset values: TIE_NoC_IN_PopReq=0, TIE_NoC_OUT_PushReq=0, TIE_NoC_OUT=0, busy=0, pkt_count=0.

## Timing
- Descriptor popped at edge N → header pushed at edge N+1 at the earliest.
- Payload word k is pushed at edge N+2+k at the earliest; tail at N+2+len.
- Best-case packet occupancy is len+3 cycles; the next descriptor can be popped at edge N+3+len.
- PAYLOAD is zero-bubble: one word per cycle while the source is not empty and the destination is not full.
- Stalls on either side hold all state; no word is lost or duplicated.
- Req outputs are combinational from state plus Empty/Full. There is no combinational path from Req to Empty/Full.
- The queues update 1 time unit after the edge; inputs must be sampled at the edge only.

## Structure
- Shared package noc_pkt_pkg:
  - FSM state encoding.
  - Descriptor and header field positions: DEST_MSB/LSB, LEN_MSB/LSB, SEQ position.
  - Width constants FLIT_W=32, LEN_W=8, SEQ_W=8.
  - A header-assembly function.
- No sub-module; a single module of about 150–200 lines.

## Test plan
- Single packet: source holds 32'h05_0000_02, 32'hAAAA0000, 32'h0000BBBB; SRC_ID=8'h03.
  - Required pushes: 32'h05030002, 32'hAAAA0000, 32'h0000BBBB, 32'hAAAABBBB.
  - pkt_count=1; busy low afterwards.
- Zero-length packet: descriptor 32'h07000000.
  - Required pushes: 32'h07030000, then 32'h00000000.
  - Exactly 2 pushes.
- Back-pressure: hold Full=1 for 5 cycles in the middle of PAYLOAD of a len=4 packet.
  - No push or pop while Full=1.
  - Payload order preserved; tail correct.
- Source underflow: present Empty=1 for 3 cycles between payload words 1 and 2.
  - PopReq and PushReq stay 0; counter holds.
  - Packet completes correctly.
- Sequence wrap: send 257 len=1 packets.
  - Header seq field goes 00…FF then 00; pkt_count=257.
- Reset mid-PAYLOAD: assert RST after 2 of 4 payload words.
  - Outputs go to reset values immediately; no tail is pushed.
  - The next descriptor starts at seq=0.

Source files
------------

// File: rtl/noc_pkt_pkg.sv
// Shared definitions for the NoC packet transmitter: FSM encoding, descriptor/header
// field positions, widths and the header-assembly helper.
package noc_pkt_pkg;

    localparam int FLIT_W = 32;
    localparam int LEN_W  = 8;
    localparam int SEQ_W  = 8;

    localparam int DEST_MSB = 31;
    localparam int DEST_LSB = 24;
    localparam int SRC_MSB  = 23;
    localparam int SRC_LSB  = 16;
    localparam int SEQ_MSB  = 15;
    localparam int SEQ_LSB  = 8;
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 0;

    localparam int DEST_W = DEST_MSB - DEST_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_TAIL    = 2'd3
    } tx_state_t;

    function automatic logic [FLIT_W-1:0] build_header(
        input logic [DEST_W-1:0] dest,
        input logic [7:0]        src,
        input logic [SEQ_W-1:0]  seq,
        input logic [LEN_W-1:0]  len
    );
        return {dest, src, seq, len};
    endfunction

endpackage

// File: rtl/noc_packet_tx.sv
// Pops a descriptor plus payload from a source TIE queue and pushes a framed packet
// (header, payload pass-through, XOR checksum tail) into a destination TIE queue.
module noc_packet_tx
    import noc_pkt_pkg::*;
#(
    parameter logic [7:0] SRC_ID = 8'h00
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [FLIT_W-1:0] TIE_NoC_IN,
    input  logic              TIE_NoC_IN_Empty,
    output logic              TIE_NoC_IN_PopReq,
    output logic [FLIT_W-1:0] TIE_NoC_OUT,
    input  logic              TIE_NoC_OUT_Full,
    output logic              TIE_NoC_OUT_PushReq,
    output logic              busy,
    output logic [15:0]       pkt_count
);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [DEST_W-1:0] dest_q;
    logic [LEN_W-1:0]  len_q;
    logic [SEQ_W-1:0]  seq_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [FLIT_W-1:0] csum_q;
    logic [15:0]       pkt_cnt_q;

    logic              pop;
    logic              push;
    logic [FLIT_W-1:0] flit;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        push      = 1'b0;
        flit      = '0;
        case (state)
            ST_IDLE: begin
                pop = !TIE_NoC_IN_Empty;
                if (pop) state_nxt = ST_HDR;
            end
            ST_HDR: begin
                flit = build_header(dest_q, SRC_ID, seq_q, len_q);
                push = !TIE_NoC_OUT_Full;
                if (push) state_nxt = (len_q != '0) ? ST_PAYLOAD : ST_TAIL;
            end
            ST_PAYLOAD: begin
                // Pop and push move together so a word is never held inside the block.
                pop  = !TIE_NoC_IN_Empty && !TIE_NoC_OUT_Full;
                push = pop;
                flit = TIE_NoC_IN;
                if (push && cnt_q == 8'd1) state_nxt = ST_TAIL;
            end
            ST_TAIL: begin
                flit = csum_q;
                push = !TIE_NoC_OUT_Full;
                if (push) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Requests are masked while reset is held so nothing transfers in the reset cycle.
    assign TIE_NoC_IN_PopReq   = pop  & ~RST;
    assign TIE_NoC_OUT_PushReq = push & ~RST;
    assign TIE_NoC_OUT         = flit;
    assign busy                = (state != ST_IDLE);
    assign pkt_count           = pkt_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            dest_q    <= '0;
            len_q     <= '0;
            seq_q     <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        dest_q <= TIE_NoC_IN[DEST_MSB:DEST_LSB];
                        len_q  <= TIE_NoC_IN[LEN_MSB:LEN_LSB];
                        csum_q <= '0;
                    end
                end
                ST_HDR: begin
                    if (push) cnt_q <= len_q;
                end
                ST_PAYLOAD: begin
                    if (push) begin
                        csum_q <= csum_q ^ TIE_NoC_IN;
                        cnt_q  <= cnt_q - 8'd1;
                    end
                end
                ST_TAIL: begin
                    if (push) begin
                        seq_q     <= seq_q + 8'd1;
                        pkt_cnt_q <= pkt_cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
